fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-003 SHALL have port ireq, output, ibus_req_t, instruction bus request: valid, addr (64).
REQ-004 SHALL have port iresp, input, ibus_resp_t, bus response: addr_ok (ignored), data_ok, data (32).
REQ-005 SHALL have port stall, input, 1, downstream cannot accept dataF this cycle.
REQ-006 SHALL have port redirect, input, 1, single-cycle pulse: taken branch/jump from a later stage.
REQ-007 SHALL have port redirect_pc, input, 64, target address, qualified by redirect.
REQ-008 SHALL have port dataF, output, fetch_data_t, registered {instr, pc, valid} to decode.
REQ-009 SHALL have parameter PCINIT, default 64'h8000_0000, first fetch address.

Function
REQ-010 SHALL implement FSM states IDLE, FETCH, HOLD, DISCARD; at most one outstanding bus request.
REQ-011 IDLE: ireq.valid=0; SHALL go to FETCH on the first clock after reset deasserts.
REQ-012 FETCH: ireq.valid=1, ireq.addr=pc, both held stable until iresp.data_ok.
REQ-013 FETCH, data_ok=1, redirect=0: dataF <= {iresp.data, pc, 1}; pc <= pc+4 (64-bit wrap); go HOLD.
REQ-014 FETCH, data_ok=1, redirect=1: response dropped; dataF.valid stays 0; pc <= redirect_pc; stay FETCH.
REQ-015 FETCH, data_ok=0, redirect=1: pend_addr <= pc; pc <= redirect_pc; go DISCARD.
REQ-016 DISCARD: ireq.valid=1, ireq.addr=pend_addr; on data_ok drop data, go FETCH; redirect here SHALL overwrite pc with newest redirect_pc.
REQ-017 HOLD: ireq.valid=0, dataF.valid=1 held unchanged while stall=1.
REQ-018 HOLD, stall=0, redirect=0: dataF.valid <= 0; go FETCH (one bubble per instruction accepted).
REQ-019 HOLD, redirect=1 (any stall): dataF.valid <= 0; pc <= redirect_pc; go FETCH; redirect has priority over stall.
REQ-020 dataF.instr and dataF.pc SHALL change only on capture (REQ-013); otherwise held.
REQ-021 Redirect SHALL be honoured in every state except IDLE, where it is ignored.
REQ-022 stall SHALL have no effect in FETCH/DISCARD; request completes, capture occurs, HOLD absorbs stall.
REQ-023 iresp.data_ok while ireq.valid=0 SHALL be ignored.

Reset
REQ-024 On reset assertion (asynchronous): state=IDLE, pc=PCINIT, pend_addr=0, dataF={0,0,0}, ireq.valid=0.
REQ-025 Reset mid-request SHALL abandon the outstanding request; no data captured afterwards until a new FETCH.

Structure
REQ-026 PCINIT and ibus_req_t/ibus_resp_t SHALL reside in package common; fetch_data_t and fetch_state_t enum in package pipes.
REQ-027 One sub-module pcselect SHALL compute next pc (pc+4 vs redirect_pc); FSM and registers stay in fetch_unit.

Verification
REQ-028 Reset release, data_ok after 2 cycles with data=32'h00000013 -> ireq.addr=8000_0000 stable 3 cycles; dataF={00000013, 8000_0000, 1}; next request addr 8000_0004.
REQ-029 HOLD with stall=1 for 5 cycles -> dataF constant, ireq.valid=0 throughout; stall=0 -> dataF.valid=0 next cycle, request at pc+4.
REQ-030 Redirect to 8000_0100 while request to 8000_0008 pending -> addr held 8000_0008 until data_ok, data discarded, next request 8000_0100.
REQ-031 Redirect to 8000_0200 same cycle as data_ok -> dataF.valid stays 0; next ireq.addr=8000_0200.
REQ-032 Redirect to 8000_0040 in HOLD with stall=1 -> dataF.valid=0 next cycle, request 8000_0040.
REQ-033 Reset asserted during DISCARD -> immediately ireq.valid=0, dataF.valid=0; after release first request at 8000_0000.

Source files
------------

// File: rtl/common.sv
// Shared bus types and reset vector for the instruction-side interface.
package common;

   localparam logic [63:0] PCINIT = 64'h8000_0000;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;

endpackage

// File: rtl/pipes.sv
// Pipeline-stage payload types and the fetch controller state encoding.
package pipes;

   typedef struct packed {
      logic [31:0] instr;
      logic [63:0] pc;
      logic        valid;
   } fetch_data_t;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StHold,
      StDiscard
   } fetch_state_t;

endpackage

// File: rtl/pcselect.sv
// Next program counter: redirect target wins over sequential advance, else hold.
module pcselect (
   input  logic [63:0] pc,
   input  logic        advance,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   output logic [63:0] next_pc
);

   always_comb begin
      next_pc = pc;
      if (redirect) begin
         next_pc = redirect_pc;
      end else if (advance) begin
         next_pc = pc + 64'd4;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch controller with redirect and one-entry output hold.
module fetch_unit
   import pipes::*;
#(
   parameter logic [63:0] PCINIT = common::PCINIT
) (
   input  logic               clk,
   input  logic               reset,
   output common::ibus_req_t  ireq,
   input  common::ibus_resp_t iresp,
   input  logic               stall,
   input  logic               redirect,
   input  logic [63:0]        redirect_pc,
   output fetch_data_t        dataF
);

   fetch_state_t state_q, state_d;
   logic [63:0]  pc_q, pc_d;
   logic [63:0]  pend_q, pend_d;
   fetch_data_t  data_q, data_d;
   logic         advance;
   logic         take_redirect;
   logic         unused_addr_ok;

   assign unused_addr_ok = iresp.addr_ok;

   pcselect u_pcselect (
      .pc          (pc_q),
      .advance     (advance),
      .redirect    (take_redirect),
      .redirect_pc (redirect_pc),
      .next_pc     (pc_d)
   );

   always_comb begin
      state_d       = state_q;
      pend_d        = pend_q;
      data_d        = data_q;
      advance       = 1'b0;
      take_redirect = 1'b0;
      ireq.valid    = 1'b0;
      ireq.addr     = pc_q;
      unique case (state_q)
         StIdle: begin
            state_d = StFetch;
         end
         StFetch: begin
            ireq.valid = 1'b1;
            if (iresp.data_ok) begin
               if (redirect) begin
                  take_redirect = 1'b1;
               end else begin
                  data_d.instr = iresp.data;
                  data_d.pc    = pc_q;
                  data_d.valid = 1'b1;
                  advance      = 1'b1;
                  state_d      = StHold;
               end
            end else if (redirect) begin
               // Request must still complete at its original address.
               pend_d        = pc_q;
               take_redirect = 1'b1;
               state_d       = StDiscard;
            end
         end
         StDiscard: begin
            ireq.valid    = 1'b1;
            ireq.addr     = pend_q;
            take_redirect = redirect;
            if (iresp.data_ok) begin
               state_d = StFetch;
            end
         end
         StHold: begin
            if (redirect) begin
               data_d.valid  = 1'b0;
               take_redirect = 1'b1;
               state_d       = StFetch;
            end else if (!stall) begin
               data_d.valid = 1'b0;
               state_d      = StFetch;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         pc_q    <= PCINIT;
         pend_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         data_q  <= data_d;
      end
   end

   assign dataF = data_q;

endmodule
